// File: rtl/video_pattern_pkg.sv
// rtl/video_pattern_pkg.sv - mode codes, default 640x480@60 timing and timing helpers
package video_pattern_pkg;

   // pattern selection codes; 4..7 are black
   localparam logic [2:0] MODE_GRID    = 3'd0;
   localparam logic [2:0] MODE_BARS    = 3'd1;
   localparam logic [2:0] MODE_CHECKER = 3'd2;
   localparam logic [2:0] MODE_SCROLL  = 3'd3;

   // default 640x480@60 timing
   localparam int DEF_H_DISPLAY = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;
   localparam int DEF_V_DISPLAY = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;
   localparam int DEF_CNT_W     = 10;

   // full period of one axis from its visible, porch and sync lengths
   function automatic int total_width(input int display, input int front,
                                      input int sync, input int back);
      return display + front + sync + back;
   endfunction

endpackage

// File: rtl/video_timing_core.sv
// rtl/video_timing_core.sv - h/v counters, sync and display decode, frame-boundary strobe
module video_timing_core
   import video_pattern_pkg::*;
#(
   parameter int H_DISPLAY = DEF_H_DISPLAY,
   parameter int H_FRONT   = DEF_H_FRONT,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BACK    = DEF_H_BACK,
   parameter int V_DISPLAY = DEF_V_DISPLAY,
   parameter int V_FRONT   = DEF_V_FRONT,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BACK    = DEF_V_BACK,
   parameter bit SYNC_POL  = 1'b0,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   output logic [CNT_W-1:0] h_o,
   output logic [CNT_W-1:0] v_o,
   output logic             run_o,
   output logic             h_last_o,
   output logic             frame_end_o,
   output logic             hsync_o,
   output logic             vsync_o,
   output logic             display_on_o
);

   localparam int H_TOTAL = total_width(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
   localparam int V_TOTAL = total_width(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
   localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
   localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_DISPLAY + H_FRONT);
   localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_DISPLAY + V_FRONT);
   localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic [CNT_W-1:0] h_q, h_d;
   logic [CNT_W-1:0] v_q, v_d;
   logic             run_q;
   logic             h_last;
   logic             v_last;

   assign h_last = (h_q == H_LAST);
   assign v_last = (v_q == V_LAST);

   // next counter position; the first clock after reset only loads (0,0)
   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (run_q) begin
         if (h_last) begin
            h_d = '0;
            v_d = v_last ? '0 : v_q + CNT_W'(1);
         end else begin
            h_d = h_q + CNT_W'(1);
         end
      end
   end

   // counter and run-flag registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         run_q <= 1'b0;
         h_q   <= '0;
         v_q   <= '0;
      end else begin
         run_q <= 1'b1;
         h_q   <= h_d;
         v_q   <= v_d;
      end
   end

   assign h_o          = h_q;
   assign v_o          = v_q;
   assign run_o        = run_q;
   assign h_last_o     = run_q & h_last;
   assign frame_end_o  = run_q & h_last & v_last;
   assign hsync_o      = ((h_q >= HS_FIRST) && (h_q <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
   assign vsync_o      = ((v_q >= VS_FIRST) && (v_q <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
   assign display_on_o = (h_q < H_VIS) && (v_q < V_VIS);

endmodule

// File: rtl/video_pattern_gen.sv
// rtl/video_pattern_gen.sv - video timing plus run-time selectable RGB test patterns
module video_pattern_gen
   import video_pattern_pkg::*;
#(
   parameter int H_DISPLAY = DEF_H_DISPLAY,
   parameter int H_FRONT   = DEF_H_FRONT,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BACK    = DEF_H_BACK,
   parameter int V_DISPLAY = DEF_V_DISPLAY,
   parameter int V_FRONT   = DEF_V_FRONT,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BACK    = DEF_V_BACK,
   parameter bit SYNC_POL  = 1'b0,
   parameter int BPC       = 1,
   parameter int CNT_W     = DEF_CNT_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [2:0]         mode_in,
   output logic               hsync,
   output logic               vsync,
   output logic               display_on,
   output logic [CNT_W-1:0]   hpos,
   output logic [CNT_W-1:0]   vpos,
   output logic [3*BPC-1:0]   rgb,
   output logic               frame_start,
   output logic [7:0]         frame_cnt
);

   localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_DISPLAY / 8 - 1);

   logic [CNT_W-1:0] h;
   logic [CNT_W-1:0] v;
   logic             run;
   logic             h_last;
   logic             frame_end;
   logic             hs;
   logic             vs;
   logic             de;

   video_timing_core #(
      .H_DISPLAY (H_DISPLAY),
      .H_FRONT   (H_FRONT),
      .H_SYNC    (H_SYNC),
      .H_BACK    (H_BACK),
      .V_DISPLAY (V_DISPLAY),
      .V_FRONT   (V_FRONT),
      .V_SYNC    (V_SYNC),
      .V_BACK    (V_BACK),
      .SYNC_POL  (SYNC_POL),
      .CNT_W     (CNT_W)
   ) u_timing (
      .clk_i        (clk),
      .rst_ni       (reset),
      .h_o          (h),
      .v_o          (v),
      .run_o        (run),
      .h_last_o     (h_last),
      .frame_end_o  (frame_end),
      .hsync_o      (hs),
      .vsync_o      (vs),
      .display_on_o (de)
   );

   logic [2:0]       mode_q;
   logic [7:0]       fcnt_q;
   logic [CNT_W-1:0] bar_sub_q;
   logic [2:0]       bar_idx_q;

   // mode and frame count only move on the frame boundary, so a frame is never split
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mode_q <= MODE_GRID;
         fcnt_q <= 8'd0;
      end else if (frame_end) begin
         mode_q <= mode_in;
         fcnt_q <= fcnt_q + 8'd1;
      end
   end

   // bar sub-counter and index follow h, restarting at the start of each line
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bar_sub_q <= '0;
         bar_idx_q <= 3'd0;
      end else if (run) begin
         if (h_last) begin
            bar_sub_q <= '0;
            bar_idx_q <= 3'd0;
         end else if (bar_sub_q == BAR_LAST) begin
            bar_sub_q <= '0;
            bar_idx_q <= bar_idx_q + 3'd1;
         end else begin
            bar_sub_q <= bar_sub_q + CNT_W'(1);
         end
      end
   end

   logic [7:0]       scroll_s;
   logic [2:0]       bar_col;
   logic [BPC-1:0]   r_c;
   logic [BPC-1:0]   g_c;
   logic [BPC-1:0]   b_c;
   logic [3*BPC-1:0] rgb_d;

   // pattern mux for the pixel the counter currently points at
   always_comb begin
      scroll_s = 8'(h) + 8'(v) + fcnt_q;
      bar_col  = 3'd7 - bar_idx_q;
      r_c      = '0;
      g_c      = '0;
      b_c      = '0;
      case (mode_q)
         MODE_GRID: begin
            r_c = {BPC{(h[2:0] == 3'd0) || (v[2:0] == 3'd0)}};
            g_c = {BPC{v[4]}};
            b_c = {BPC{h[4]}};
         end
         MODE_BARS: begin
            r_c = {BPC{bar_col[0]}};
            g_c = {BPC{bar_col[1]}};
            b_c = {BPC{bar_col[2]}};
         end
         MODE_CHECKER: begin
            r_c = {BPC{h[5] ^ v[5]}};
            g_c = {BPC{h[5] ^ v[5]}};
            b_c = {BPC{h[5] ^ v[5]}};
         end
         MODE_SCROLL: begin
            r_c = scroll_s[7 -: BPC];
            g_c = ~scroll_s[7 -: BPC];
         end
         default: ;
      endcase
      rgb_d = de ? {b_c, g_c, r_c} : '0;
   end

   logic               hsync_q;
   logic               vsync_q;
   logic               de_q;
   logic [CNT_W-1:0]   hpos_q;
   logic [CNT_W-1:0]   vpos_q;
   logic [3*BPC-1:0]   rgb_q;
   logic               fs_q;
   logic [7:0]         fcnt_out_q;

   // single output register keeps every pin describing the same pixel
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hsync_q    <= ~SYNC_POL;
         vsync_q    <= ~SYNC_POL;
         de_q       <= 1'b0;
         hpos_q     <= '0;
         vpos_q     <= '0;
         rgb_q      <= '0;
         fs_q       <= 1'b0;
         fcnt_out_q <= 8'd0;
      end else if (run) begin
         hsync_q    <= hs;
         vsync_q    <= vs;
         de_q       <= de;
         hpos_q     <= h;
         vpos_q     <= v;
         rgb_q      <= rgb_d;
         fs_q       <= (h == '0) && (v == '0);
         fcnt_out_q <= fcnt_q;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign display_on  = de_q;
   assign hpos        = hpos_q;
   assign vpos        = vpos_q;
   assign rgb         = rgb_q;
   assign frame_start = fs_q;
   assign frame_cnt   = fcnt_out_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb/tb_video_pattern_gen.sv - randomized self-checking bench with a frame-arithmetic reference model
module tb_video_pattern_gen;

   localparam int HD  [3] = '{64, 16, 24};
   localparam int HF  [3] = '{4, 1, 2};
   localparam int HS  [3] = '{8, 2, 3};
   localparam int HB  [3] = '{4, 1, 3};
   localparam int VD  [3] = '{20, 4, 6};
   localparam int VF  [3] = '{2, 1, 1};
   localparam int VS  [3] = '{2, 1, 2};
   localparam int VB  [3] = '{3, 1, 1};
   localparam int POL [3] = '{0, 1, 0};
   localparam int BPC [3] = '{1, 4, 2};

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        de;
      logic [7:0]  x;
      logic [7:0]  y;
      logic [11:0] rgb;
      logic        fs;
      logic [7:0]  fc;
   } obs_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [2:0] mode_in0 = 3'd0, mode_in1 = 3'd0, mode_in2 = 3'd0;

   logic hsync0, vsync0, de0, fs0;
   logic hsync1, vsync1, de1, fs1;
   logic hsync2, vsync2, de2, fs2;
   logic [7:0] hpos0, vpos0, fc0, hpos1, vpos1, fc1, hpos2, vpos2, fc2;
   logic [2:0]  rgb0;
   logic [11:0] rgb1;
   logic [5:0]  rgb2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   video_pattern_gen #(.H_DISPLAY(HD[0]), .H_FRONT(HF[0]), .H_SYNC(HS[0]), .H_BACK(HB[0]),
      .V_DISPLAY(VD[0]), .V_FRONT(VF[0]), .V_SYNC(VS[0]), .V_BACK(VB[0]),
      .SYNC_POL(POL[0] != 0), .BPC(BPC[0]), .CNT_W(8)) dut0 (
      .clk(clk), .reset(reset), .mode_in(mode_in0), .hsync(hsync0), .vsync(vsync0),
      .display_on(de0), .hpos(hpos0), .vpos(vpos0), .rgb(rgb0), .frame_start(fs0), .frame_cnt(fc0));

   video_pattern_gen #(.H_DISPLAY(HD[1]), .H_FRONT(HF[1]), .H_SYNC(HS[1]), .H_BACK(HB[1]),
      .V_DISPLAY(VD[1]), .V_FRONT(VF[1]), .V_SYNC(VS[1]), .V_BACK(VB[1]),
      .SYNC_POL(POL[1] != 0), .BPC(BPC[1]), .CNT_W(8)) dut1 (
      .clk(clk), .reset(reset), .mode_in(mode_in1), .hsync(hsync1), .vsync(vsync1),
      .display_on(de1), .hpos(hpos1), .vpos(vpos1), .rgb(rgb1), .frame_start(fs1), .frame_cnt(fc1));

   video_pattern_gen #(.H_DISPLAY(HD[2]), .H_FRONT(HF[2]), .H_SYNC(HS[2]), .H_BACK(HB[2]),
      .V_DISPLAY(VD[2]), .V_FRONT(VF[2]), .V_SYNC(VS[2]), .V_BACK(VB[2]),
      .SYNC_POL(POL[2] != 0), .BPC(BPC[2]), .CNT_W(8)) dut2 (
      .clk(clk), .reset(reset), .mode_in(mode_in2), .hsync(hsync2), .vsync(vsync2),
      .display_on(de2), .hpos(hpos2), .vpos(vpos2), .rgb(rgb2), .frame_start(fs2), .frame_cnt(fc2));

   function automatic int htot(input int i);
      return HD[i] + HF[i] + HS[i] + HB[i];
   endfunction

   function automatic int flen(input int i);
      return htot(i) * (VD[i] + VF[i] + VS[i] + VB[i]);
   endfunction

   // expected outputs for output pixel number p since the restart, in a frame shown with mode
   function automatic obs_t model_pix(input int i, input int p, input int mode);
      obs_t o;
      int ht, vt, x, y, f, full, r, g, b, c, s;
      ht   = htot(i);
      vt   = VD[i] + VF[i] + VS[i] + VB[i];
      x    = p % ht;
      y    = (p / ht) % vt;
      f    = p / (ht * vt);
      full = (1 << BPC[i]) - 1;
      r = 0; g = 0; b = 0;
      case (mode)
         0: begin
            r = (x % 8 == 0 || y % 8 == 0) ? full : 0;
            g = ((y / 16) % 2 == 1) ? full : 0;
            b = ((x / 16) % 2 == 1) ? full : 0;
         end
         1: begin
            c = 7 - (x / (HD[i] / 8));
            r = (c % 2 == 1) ? full : 0;
            g = ((c / 2) % 2 == 1) ? full : 0;
            b = ((c / 4) % 2 == 1) ? full : 0;
         end
         2: begin
            r = (((x / 32) + (y / 32)) % 2 == 1) ? full : 0;
            g = r;
            b = r;
         end
         3: begin
            s = (x + y + f) % 256;
            r = s >> (8 - BPC[i]);
            g = full - r;
         end
         default: ;
      endcase
      o.de  = (x < HD[i]) && (y < VD[i]);
      o.hs  = (x >= HD[i] + HF[i] && x < HD[i] + HF[i] + HS[i]) ? (POL[i] != 0) : (POL[i] == 0);
      o.vs  = (y >= VD[i] + VF[i] && y < VD[i] + VF[i] + VS[i]) ? (POL[i] != 0) : (POL[i] == 0);
      o.x   = 8'(x);
      o.y   = 8'(y);
      o.rgb = o.de ? 12'((b << (2 * BPC[i])) | (g << BPC[i]) | r) : 12'd0;
      o.fs  = (x == 0) && (y == 0);
      o.fc  = 8'(f % 256);
      return o;
   endfunction

   function automatic obs_t model_rst(input int i);
      obs_t o;
      o    = '0;
      o.hs = (POL[i] == 0);
      o.vs = (POL[i] == 0);
      return o;
   endfunction

   function automatic obs_t act_obs(input int i);
      obs_t o;
      case (i)
         0:       o = {hsync0, vsync0, de0, hpos0, vpos0, 12'(rgb0), fs0, fc0};
         1:       o = {hsync1, vsync1, de1, hpos1, vpos1, rgb1, fs1, fc1};
         default: o = {hsync2, vsync2, de2, hpos2, vpos2, 12'(rgb2), fs2, fc2};
      endcase
      return o;
   endfunction

   function automatic int mode_val(input int i);
      case (i)
         0:       return int'(mode_in0);
         1:       return int'(mode_in1);
         default: return int'(mode_in2);
      endcase
   endfunction

   task automatic pin(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference bookkeeping: k counts edges since reset release, modes per frame
   int k = 0;
   int cur_mode [3] = '{0, 0, 0};
   int next_mode [3] = '{0, 0, 0};

   always @(posedge clk) begin
      if (!reset) begin
         k = 0;
         for (int i = 0; i < 3; i++) begin
            cur_mode[i]  = 0;
            next_mode[i] = 0;
         end
      end else begin
         k = k + 1;
         if (k >= 2) begin
            for (int i = 0; i < 3; i++) begin
               if ((k - 2) > 0 && (k - 2) % flen(i) == 0) cur_mode[i] = next_mode[i];
               if ((k - 2) % flen(i) == flen(i) - 1) next_mode[i] = mode_val(i);
            end
         end
      end
   end

   // compare process: every DUT against the model on every falling edge
   int cyc = 0;
   int de_cnt0 = 0;
   int last_fs2 = -1;

   always @(negedge clk) begin
      obs_t a, e;
      int p, x0, y0, f1;
      cyc++;
      for (int i = 0; i < 3; i++) begin
         a = act_obs(i);
         if (!reset || k < 2) e = model_rst(i);
         else e = model_pix(i, k - 2, cur_mode[i]);
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL pixel dut%0d k=%0d: got %h want %h", i, k, a, e);
         end
      end
      if (!reset) begin
         last_fs2 = -1;
      end else if (k >= 2) begin
         p  = k - 2;
         x0 = p % htot(0);
         y0 = (p / htot(0)) % (VD[0] + VF[0] + VS[0] + VB[0]);
         if (cur_mode[0] == 1 && y0 < VD[0]) begin
            case (x0)
               0, 7:       pin("bars_white", 32'(rgb0), 32'h7);
               8:          pin("bars_second", 32'(rgb0), 32'h6);
               55:         pin("bars_sixth", 32'(rgb0), 32'h1);
               56, 63, 64: pin("bars_black_or_blank", 32'(rgb0), 32'h0);
               default: ;
            endcase
         end
         case (x0)
            67, 76: pin("hsync_idle", 32'(hsync0), 32'h1);
            68, 75: pin("hsync_active", 32'(hsync0), 32'h0);
            default: ;
         endcase
         if (x0 == 0) begin
            case (y0)
               21, 24: pin("vsync_idle", 32'(vsync0), 32'h1);
               22, 23: pin("vsync_active", 32'(vsync0), 32'h0);
               default: ;
            endcase
         end
         if (x0 == 0 && y0 == 0) de_cnt0 = 0;
         if (de0) de_cnt0++;
         if (p % flen(0) == flen(0) - 1) pin("display_on_count", 32'(de_cnt0), 32'd1280);
         f1 = p / flen(1);
         if (fs1) begin
            if (f1 == 3 && cur_mode[1] == 3) pin("scroll_f3_rgb", 32'(rgb1), 32'h0F0);
            if (f1 == 255) pin("frame_cnt_255", 32'(fc1), 32'hFF);
            if (f1 == 256) pin("frame_cnt_wrap", 32'(fc1), 32'h0);
         end
         if (p == 0)  pin("grid_bpc2_origin", 32'(rgb2), 32'h03);
         if (p == 16) pin("grid_bpc2_x16", 32'(rgb2), 32'h33);
         if (fs2) begin
            if (last_fs2 >= 0) pin("frame_period", 32'(cyc - last_fs2), 32'd320);
            last_fs2 = cyc;
         end
      end
   end

   task automatic drive(input int c);
      mode_in0 = (c < 3000) ? 3'd1 : 3'($urandom_range(0, 7));
      mode_in1 = (c < 3000) ? 3'd3 : 3'($urandom_range(0, 7));
      mode_in2 = 3'($urandom_range(0, 7));
   endtask

   initial begin
      obs_t m;
      m = model_pix(0, 68, 0);
      pin("model_hsync_start", 32'(m.hs), 32'h0);
      m = model_pix(1, 3 * 140, 3);
      pin("model_scroll", 32'(m.rgb), 32'h0F0);
      m = model_pix(0, 8, 1);
      pin("model_bars", 32'(m.rgb), 32'h6);
      m = model_pix(2, 320, 0);
      pin("model_frame_cnt", 32'({m.fs, m.fc}), 32'h101);

      repeat (3) @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         drive(c);
      end

      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      pin("rst_c0_sync", 32'({hsync0, vsync0}), 32'h3);
      pin("rst_c1_sync", 32'({hsync1, vsync1}), 32'h0);
      pin("rst_c0_rgb_de", 32'({rgb0, de0, fs0}), 32'h0);
      pin("rst_c0_pos", 32'({hpos0, vpos0}), 32'h0);
      pin("rst_c1_cnt", 32'({fc1, rgb1}), 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 38000; c++) begin
         @(negedge clk);
         drive(c);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
